// File: rtl/hdc1000_i2c_target_pkg.sv
// Shared encodings and pointer map for the HDC1000 I2C target model.
package hdc1000_i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WR,
    ST_WR_ACK,
    ST_RD,
    ST_RD_ACK
  } state_t;

  localparam logic [7:0] P_TEMP = 8'h00;
  localparam logic [7:0] P_HUM  = 8'h01;
  localparam logic [7:0] P_CFG  = 8'h02;
  localparam logic [7:0] P_MFG  = 8'hFE;
  localparam logic [7:0] P_DEV  = 8'hFF;

  // Pointers the device acknowledges.
  function automatic logic ptr_valid(input logic [7:0] p);
    return (p == P_TEMP) || (p == P_HUM) || (p == P_CFG) || (p == P_MFG) || (p == P_DEV);
  endfunction

  // Pointers whose write starts a measurement.
  function automatic logic ptr_triggers(input logic [7:0] p);
    return (p == P_TEMP) || (p == P_HUM);
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Synchronizes SCL/SDA into CLK_50 and produces edge and START/STOP strobes.
module i2c_bus_monitor
  import hdc1000_i2c_target_pkg::*;
(
  input  logic CLK_50,
  input  logic RESET_N,
  input  logic SCL_IN,
  input  logic SDA_IN,
  output logic sda_lvl,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] = two-stage synchronizer, [2] = history for edge detection
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // Shift the bus lines in; reset to the idle (released-high) level so no false edges appear.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], SCL_IN};
      sda_q <= {sda_q[1:0], SDA_IN};
    end
  end

  assign sda_lvl   = sda_q[1];
  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];

endmodule

// File: rtl/hdc1000_i2c_target.sv
// HDC1000 register-map emulation behind an I2C target, with DRDY_n conversion timer.
module hdc1000_i2c_target
  import hdc1000_i2c_target_pkg::*;
#(
  parameter logic [7:0]  SLAVE_ADDR  = 8'h80,
  parameter logic [15:0] MFG_ID      = 16'h5449,
  parameter logic [15:0] DEV_ID      = 16'h1000,
  parameter logic [31:0] CONV_CYCLES = 32'd1000,
  parameter logic [15:0] CFG_RESET   = 16'h1000
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        SCL_IN,
  input  logic        SDA_IN,
  output logic        SDA_OE,
  output logic        DRDY_n,
  input  logic [15:0] TEMP_SAMPLE,
  input  logic [15:0] RH_SAMPLE,
  output logic [15:0] CONFIG,
  output logic        BUSY
);

  logic sda_lvl, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_monitor u_mon (
    .CLK_50    (CLK_50),
    .RESET_N   (RESET_N),
    .SCL_IN    (SCL_IN),
    .SDA_IN    (SDA_IN),
    .sda_lvl   (sda_lvl),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state, state_nxt;
  logic        sda_oe_r, oe_nxt;
  logic [3:0]  bitcnt;
  logic [7:0]  rx;
  logic [15:0] sr;
  logic [1:0]  wr_cnt;
  logic [7:0]  cfg_msb;
  logic [15:0] config_r;
  logic [7:0]  ptr;
  logic        mst_ack;
  logic        busy_r;
  logic [31:0] conv_cnt;
  logic        drdy_n_r;
  logic [15:0] temp_l, rh_l;
  logic [15:0] rd_word;

  // Bus events win over a data edge seen in the same cycle.
  wire rise      = scl_rise & ~start_det & ~stop_det;
  wire fall      = scl_fall & ~start_det & ~stop_det;
  wire byte_done = (bitcnt == 4'd8);
  wire addr_hit  = (rx[7:1] == SLAVE_ADDR[7:1]);
  wire conv_pend = drdy_n_r & ptr_triggers(ptr);
  wire addr_ack  = addr_hit & ~(rx[0] & conv_pend);
  wire wr_ok     = (ptr == P_CFG) && (wr_cnt != 2'd2);
  wire trig      = (state == ST_PTR) && fall && byte_done && ptr_triggers(rx);

  // Select the 16-bit register addressed by the stored pointer.
  always_comb begin
    rd_word = 16'hFFFF;
    case (ptr)
      P_TEMP:  rd_word = temp_l;
      P_HUM:   rd_word = rh_l;
      P_CFG:   rd_word = config_r;
      P_MFG:   rd_word = MFG_ID;
      P_DEV:   rd_word = DEV_ID;
      default: rd_word = 16'hFFFF;
    endcase
  end

  // Next state and next SDA drive; drive changes only on an SCL fall, which the
  // synchronizer already delays by 2-3 CLK_50 cycles, giving the data hold time.
  always_comb begin
    state_nxt = state;
    oe_nxt    = sda_oe_r;
    if (stop_det) begin
      state_nxt = ST_IDLE;
      oe_nxt    = 1'b0;
    end else if (start_det) begin
      state_nxt = ST_ADDR;
      oe_nxt    = 1'b0;
    end else if (fall) begin
      case (state)
        ST_IDLE: oe_nxt = 1'b0;
        ST_ADDR: if (byte_done) begin
          state_nxt = addr_ack ? ST_ADDR_ACK : ST_IDLE;
          oe_nxt    = addr_ack;
        end
        ST_ADDR_ACK: begin
          state_nxt = rx[0] ? ST_RD : ST_PTR;
          oe_nxt    = rx[0] ? ~rd_word[15] : 1'b0;
        end
        ST_PTR: if (byte_done) begin
          state_nxt = ST_PTR_ACK;
          oe_nxt    = ptr_valid(rx);
        end
        ST_PTR_ACK, ST_WR_ACK: begin
          state_nxt = ST_WR;
          oe_nxt    = 1'b0;
        end
        ST_WR: if (byte_done) begin
          state_nxt = ST_WR_ACK;
          oe_nxt    = wr_ok;
        end
        ST_RD: begin
          state_nxt = byte_done ? ST_RD_ACK : ST_RD;
          oe_nxt    = byte_done ? 1'b0 : ~sr[14];
        end
        ST_RD_ACK: begin
          state_nxt = mst_ack ? ST_RD : ST_IDLE;
          oe_nxt    = mst_ack ? ~sr[14] : 1'b0;
        end
        default: begin
          state_nxt = ST_IDLE;
          oe_nxt    = 1'b0;
        end
      endcase
    end
  end

  // State register and SDA drive; reset releases SDA asynchronously.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state    <= ST_IDLE;
      sda_oe_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      sda_oe_r <= oe_nxt;
    end
  end

  // Bit counting, shift registers, pointer and configuration register.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      bitcnt   <= 4'd0;
      rx       <= 8'h00;
      sr       <= 16'hFFFF;
      wr_cnt   <= 2'd0;
      cfg_msb  <= 8'h00;
      config_r <= CFG_RESET;
      ptr      <= P_TEMP;
      mst_ack  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      if (start_det || (state_nxt != state))
        bitcnt <= 4'd0;
      else if (rise && !byte_done && (state inside {ST_ADDR, ST_PTR, ST_WR, ST_RD}))
        bitcnt <= bitcnt + 4'd1;
      if (rise && (state inside {ST_ADDR, ST_PTR, ST_WR}))
        rx <= {rx[6:0], sda_lvl};
      if (rise && (state == ST_RD_ACK))
        mst_ack <= ~sda_lvl;
      // Ones shift in behind the word so bytes past the second read as 8'hFF.
      if ((state == ST_ADDR_ACK) && (state_nxt == ST_RD))
        sr <= rd_word;
      else if (fall && (((state == ST_RD) && !byte_done) || ((state == ST_RD_ACK) && mst_ack)))
        sr <= {sr[14:0], 1'b1};
      if ((state == ST_PTR) && (state_nxt == ST_PTR_ACK) && ptr_valid(rx))
        ptr <= rx;
      if (state == ST_PTR_ACK)
        wr_cnt <= 2'd0;
      else if ((state == ST_WR) && (state_nxt == ST_WR_ACK)) begin
        if (wr_ok) begin
          if (wr_cnt == 2'd0) cfg_msb  <= rx;
          else                config_r <= {cfg_msb, rx};
        end
        if (wr_cnt != 2'd2) wr_cnt <= wr_cnt + 2'd1;
      end
      if (stop_det)
        busy_r <= 1'b0;
      else if ((state == ST_ADDR) && (state_nxt == ST_ADDR_ACK))
        busy_r <= 1'b1;
    end
  end

  // Conversion timer: a trigger latches both samples and holds DRDY_n high for CONV_CYCLES.
  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      conv_cnt <= 32'd0;
      drdy_n_r <= 1'b0;
      temp_l   <= 16'h0000;
      rh_l     <= 16'h0000;
    end else if (trig) begin
      conv_cnt <= CONV_CYCLES;
      drdy_n_r <= 1'b1;
      temp_l   <= TEMP_SAMPLE;
      rh_l     <= RH_SAMPLE;
    end else if (conv_cnt != 32'd0) begin
      conv_cnt <= conv_cnt - 32'd1;
      if (conv_cnt == 32'd1) drdy_n_r <= 1'b0;
    end
  end

  assign SDA_OE = sda_oe_r;
  assign DRDY_n = drdy_n_r;
  assign CONFIG = config_r;
  assign BUSY   = busy_r;

endmodule

// File: tb/tb_hdc1000_i2c_target.sv
// Bit-banged I2C master bench for hdc1000_i2c_target.
module tb_hdc1000_i2c_target;

  localparam int Q = 8;  // quarter SCL period in CLK_50 cycles

  logic        CLK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        SCL_IN, SDA_IN, SDA_OE, DRDY_n, BUSY;
  logic [15:0] TEMP_SAMPLE = 16'h0000;
  logic [15:0] RH_SAMPLE = 16'h0000;
  logic [15:0] CONFIG;

  int checks = 0;
  int errors = 0;
  int hcnt = 0;

  // Open-drain bus: either side can pull SDA low.
  assign SCL_IN = scl_m;
  assign SDA_IN = sda_m & ~SDA_OE;

  always #10 CLK_50 = ~CLK_50;

  always @(negedge CLK_50) if (DRDY_n) hcnt <= hcnt + 1;

  hdc1000_i2c_target dut (
    .CLK_50      (CLK_50),
    .RESET_N     (RESET_N),
    .SCL_IN      (SCL_IN),
    .SDA_IN      (SDA_IN),
    .SDA_OE      (SDA_OE),
    .DRDY_n      (DRDY_n),
    .TEMP_SAMPLE (TEMP_SAMPLE),
    .RH_SAMPLE   (RH_SAMPLE),
    .CONFIG      (CONFIG),
    .BUSY        (BUSY)
  );

  typedef struct {
    logic [7:0]  ptr;
    logic [23:0] exp;
  } rd_vec_t;

  rd_vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic q();
    repeat (Q) @(negedge CLK_50);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    sda_m = 1'b0; q();
    scl_m = 1'b0; q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; q();
    scl_m = 1'b1; q();
    sda_m = 1'b1; q();
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic acked);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; q();
      scl_m = 1'b1; q(); q();
      scl_m = 1'b0; q();
    end
    sda_m = 1'b1; q();
    scl_m = 1'b1; q();
    acked = ~SDA_IN; q();
    scl_m = 1'b0; q();
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] b);
    b = 8'h00;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      q();
      scl_m = 1'b1; q();
      b[i] = SDA_IN; q();
      scl_m = 1'b0;
    end
    q();
    sda_m = ~ack; q();
    scl_m = 1'b1; q(); q();
    scl_m = 1'b0; q();
    sda_m = 1'b1;
  endtask

  // Pointer write, repeated START, n-byte read (last byte NACKed), STOP.
  task automatic reg_read(input logic [7:0] p, input int n, output logic [2:0] acks,
                          output logic [23:0] d);
    logic       a;
    logic [7:0] b;
    d = 24'hFFFFFF;
    i2c_start();
    wr_byte(8'h80, a); acks[2] = a;
    wr_byte(p, a);     acks[1] = a;
    i2c_start();
    wr_byte(8'h81, a); acks[0] = a;
    for (int i = 0; i < n; i++) begin
      rd_byte(i != n - 1, b);
      d[23 - 8*i -: 8] = b;
    end
    i2c_stop();
  endtask

  task automatic wait_drdy_low(input string name);
    int n = 0;
    while (DRDY_n && n < 3000) begin
      @(negedge CLK_50);
      n++;
    end
    chk(name, 32'(DRDY_n), 32'd0);
  endtask

  initial begin
    logic        a;
    logic [2:0]  acks;
    logic [23:0] d;
    logic [7:0]  b;
    int          h0;

    vecs[0] = '{ptr: 8'hFE, exp: 24'h5449FF};
    vecs[1] = '{ptr: 8'hFF, exp: 24'h1000FF};
    vecs[2] = '{ptr: 8'h02, exp: 24'h1000FF};

    // Reset state
    repeat (5) @(negedge CLK_50);
    chk("rst_sda_oe", 32'(SDA_OE), 32'd0);
    chk("rst_drdy",   32'(DRDY_n), 32'd0);
    chk("rst_config", 32'(CONFIG), 32'h1000);
    chk("rst_busy",   32'(BUSY),   32'd0);
    RESET_N = 1'b1;
    repeat (5) @(negedge CLK_50);

    // Device ID read with repeated START
    i2c_start();
    wr_byte(8'h80, a); chk("id_addr_ack", 32'(a), 32'd1);
    chk("id_busy", 32'(BUSY), 32'd1);
    wr_byte(8'hFF, a); chk("id_ptr_ack", 32'(a), 32'd1);
    i2c_start();
    wr_byte(8'h81, a); chk("id_rd_ack", 32'(a), 32'd1);
    rd_byte(1'b1, b);  chk("id_b0", 32'(b), 32'h10);
    rd_byte(1'b0, b);  chk("id_b1", 32'(b), 32'h00);
    i2c_stop();
    chk("id_busy_clr", 32'(BUSY), 32'd0);

    // Table of three-byte register reads
    for (int i = 0; i < 3; i++) begin
      reg_read(vecs[i].ptr, 3, acks, d);
      chk($sformatf("tbl%0d_acks", i), 32'(acks), 32'd7);
      chk($sformatf("tbl%0d_data", i), 32'(d), 32'(vecs[i].exp));
    end

    // Temperature conversion timing and latched read
    TEMP_SAMPLE = 16'h6540;
    RH_SAMPLE   = 16'h1234;
    h0 = hcnt;
    i2c_start();
    wr_byte(8'h80, a); chk("cv_addr_ack", 32'(a), 32'd1);
    wr_byte(8'h00, a); chk("cv_ptr_ack", 32'(a), 32'd1);
    chk("cv_drdy_high", 32'(DRDY_n), 32'd1);
    i2c_stop();
    repeat (160) @(negedge CLK_50);
    i2c_start();
    wr_byte(8'h81, a); chk("cv_mid_nack", 32'(a), 32'd0);
    i2c_stop();
    chk("cv_still_busy", 32'(DRDY_n), 32'd1);
    TEMP_SAMPLE = 16'hBEEF;
    wait_drdy_low("cv_drdy_timeout");
    chk("cv_high_cycles", 32'(hcnt - h0), 32'd1000);
    i2c_start();
    wr_byte(8'h81, a); chk("cv_rd_ack", 32'(a), 32'd1);
    rd_byte(1'b1, b);  chk("cv_t0", 32'(b), 32'h65);
    rd_byte(1'b0, b);  chk("cv_t1", 32'(b), 32'h40);
    i2c_stop();

    // Humidity trigger re-latches both samples
    RH_SAMPLE = 16'h3A7C;
    h0 = hcnt;
    i2c_start();
    wr_byte(8'h80, a); wr_byte(8'h01, a); chk("rh_ptr_ack", 32'(a), 32'd1);
    i2c_stop();
    wait_drdy_low("rh_drdy_timeout");
    chk("rh_high_cycles", 32'(hcnt - h0), 32'd1000);
    i2c_start();
    wr_byte(8'h81, a);
    rd_byte(1'b1, b); chk("rh_b0", 32'(b), 32'h3A);
    rd_byte(1'b0, b); chk("rh_b1", 32'(b), 32'h7C);
    i2c_stop();

    // Configuration write: two bytes accepted, third rejected
    i2c_start();
    wr_byte(8'h80, a); chk("cfg_addr_ack", 32'(a), 32'd1);
    wr_byte(8'h02, a); chk("cfg_ptr_ack", 32'(a), 32'd1);
    wr_byte(8'h90, a); chk("cfg_msb_ack", 32'(a), 32'd1);
    wr_byte(8'h00, a); chk("cfg_lsb_ack", 32'(a), 32'd1);
    chk("cfg_value", 32'(CONFIG), 32'h9000);
    wr_byte(8'hAA, a); chk("cfg_extra_nack", 32'(a), 32'd0);
    chk("cfg_unchanged", 32'(CONFIG), 32'h9000);
    i2c_stop();

    // Wrong address, then invalid pointer keeps the previous pointer
    i2c_start();
    wr_byte(8'h82, a); chk("bad_addr_nack", 32'(a), 32'd0);
    chk("bad_addr_busy", 32'(BUSY), 32'd0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h80, a); chk("bad_ptr_addr_ack", 32'(a), 32'd1);
    wr_byte(8'h05, a); chk("bad_ptr_nack", 32'(a), 32'd0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h81, a); chk("prev_ptr_ack", 32'(a), 32'd1);
    rd_byte(1'b1, b);  chk("prev_ptr_b0", 32'(b), 32'h90);
    rd_byte(1'b0, b);  chk("prev_ptr_b1", 32'(b), 32'h00);
    i2c_stop();

    // Reset while the target is driving a 0 bit
    i2c_start();
    wr_byte(8'h80, a); wr_byte(8'hFE, a);
    i2c_start();
    wr_byte(8'h81, a);
    chk("rr_driving", 32'(SDA_OE), 32'd1);
    #3 RESET_N = 1'b0;
    #1 chk("rr_sda_released", 32'(SDA_OE), 32'd0);
    chk("rr_config", 32'(CONFIG), 32'h1000);
    repeat (4) @(negedge CLK_50);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK_50);
    i2c_start();
    wr_byte(8'h80, a); chk("rr_addr_ack", 32'(a), 32'd1);
    wr_byte(8'h02, a); chk("rr_ptr_ack", 32'(a), 32'd1);
    i2c_stop();
    chk("rr_sda_idle", 32'(SDA_OE), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the run can never hang.
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
